// File: rtl/sha_pkg.sv
// Shared definitions for the SHA digest serializers (SHA-512/256/1 share widths,
// the serializer state type and the nibble-to-ASCII helper).
package sha_pkg;

  localparam int SHA512_DIGEST_W = 512;
  localparam int SHA_ID_W        = 32;
  localparam int SHA_LEN_W       = 61;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  // Lowercase hex: 0-9 -> '0'..'9', a-f -> 'a'..'f'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sha_digest_buf.sv
// Two-entry result buffer between the hash core (no backpressure) and the byte
// serializer; results arriving while full are dropped and flagged.
module sha_digest_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         overflow
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic         pop_ok;
  logic         accept;
  logic         drop;

  // A pop in the same cycle frees a slot, so a push into a full buffer still fits
  always_comb begin
    pop_ok = pop && (count != 2'd0);
    accept = push && ((count != 2'd2) || pop_ok);
    drop   = push && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= ~wptr;
      end
      if (pop_ok) begin
        rptr <= ~rptr;
      end
      count <= count + {1'b0, accept} - {1'b0, pop_ok};
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= wdata;
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/sha512_digest_serializer.sv
// Buffers SHA-512 results and streams each digest as raw bytes or lowercase hex,
// optionally terminated by a line feed, over a valid/ready byte interface.
module sha512_digest_serializer
  import sha_pkg::*;
#(
  parameter bit HEX = 1'b0,
  parameter bit LF  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [SHA_ID_W-1:0]        i_id,
  input  logic [SHA_LEN_W-1:0]       i_len,
  input  logic [SHA512_DIGEST_W-1:0] i_sha,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [7:0]                 o_data,
  output logic                       o_last,
  output logic [SHA_ID_W-1:0]        o_id,
  output logic [SHA_LEN_W-1:0]       o_len,
  output logic                       overflow
);

  localparam int PAYLOAD = HEX ? 128 : 64;
  localparam int N       = PAYLOAD + (LF ? 1 : 0);
  localparam int ENTRY_W = SHA_ID_W + SHA_LEN_W + SHA512_DIGEST_W;

  ser_state_e                 state;
  ser_state_e                 state_next;
  logic [7:0]                 idx;
  logic [7:0]                 idx_next;
  logic [ENTRY_W-1:0]         head;
  logic [1:0]                 count;
  logic [SHA_ID_W-1:0]        head_id;
  logic [SHA_LEN_W-1:0]       head_len;
  logic [SHA512_DIGEST_W-1:0] head_sha;
  logic [SHA_ID_W-1:0]        held_id;
  logic [SHA_LEN_W-1:0]       held_len;
  logic                       sending;
  logic                       last;
  logic                       fire;
  logic                       pop;

  assign {head_id, head_len, head_sha} = head;

  sha_digest_buf #(
    .W(ENTRY_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (i_valid),
    .pop     (pop),
    .wdata   ({i_id, i_len, i_sha}),
    .rdata   (head),
    .count   (count),
    .overflow(overflow)
  );

  always_comb begin
    sending = (state == SER_SEND);
    last    = sending && (idx == 8'(N - 1));
    fire    = sending && o_ready;
    pop     = fire && last;
  end

  // Entering SEND on the capture itself gives one cycle of input-to-output latency
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      SER_IDLE: begin
        if (i_valid || (count != 2'd0)) begin
          state_next = SER_SEND;
        end
      end
      SER_SEND: begin
        if (fire) begin
          if (last) begin
            idx_next = 8'd0;
            if ((count == 2'd1) && !i_valid) begin
              state_next = SER_IDLE;
            end
          end else begin
            idx_next = idx + 8'd1;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SER_IDLE;
      idx      <= 8'd0;
      held_id  <= '0;
      held_len <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (sending) begin
        held_id  <= head_id;
        held_len <= head_len;
      end
    end
  end

  logic [5:0]                 byte_sel;
  logic [SHA512_DIGEST_W-1:0] shifted;
  logic [7:0]                 sel_byte;
  logic [3:0]                 nib;
  logic [7:0]                 payload_byte;
  logic [7:0]                 byte_out;

  // Two hex characters per digest byte, high nibble first
  always_comb begin
    byte_sel     = HEX ? idx[6:1] : idx[5:0];
    shifted      = head_sha << {byte_sel, 3'b000};
    sel_byte     = shifted[SHA512_DIGEST_W-1 -: 8];
    nib          = idx[0] ? sel_byte[3:0] : sel_byte[7:4];
    payload_byte = HEX ? nibble_to_ascii(nib) : sel_byte;
    byte_out     = (LF && (idx == 8'(PAYLOAD))) ? 8'h0a : payload_byte;
  end

  always_comb begin
    o_valid = sending;
    o_last  = last;
    o_data  = sending ? byte_out : 8'h00;
    o_id    = sending ? head_id : held_id;
    o_len   = sending ? head_len : held_len;
  end

endmodule

// File: tb/tb_sha512_digest_serializer.sv
// Drives a raw-binary and a hex+LF serializer side by side and compares every
// cycle against a frame-level reference model.
module tb_sha512_digest_serializer;

  localparam logic [511:0] ABC = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic [31:0]        i_id = '0;
  logic [60:0]        i_len = '0;
  logic [511:0]       i_sha = '0;
  logic [1:0]         rdy = 2'b00;
  logic [1:0]         ov;
  logic [1:0]         ol;
  logic [1:0]         oovf;
  logic [1:0][7:0]    od;
  logic [1:0][31:0]   oid;
  logic [1:0][60:0]   olen;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Index 0: raw binary frames of 64 bytes; index 1: hex + LF frames of 129 bytes
  sha512_digest_serializer #(.HEX(1'b0), .LF(1'b0)) u_bin (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_id(i_id), .i_len(i_len), .i_sha(i_sha),
    .o_valid(ov[0]), .o_ready(rdy[0]), .o_data(od[0]), .o_last(ol[0]),
    .o_id(oid[0]), .o_len(olen[0]), .overflow(oovf[0])
  );

  sha512_digest_serializer #(.HEX(1'b1), .LF(1'b1)) u_hex (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_id(i_id), .i_len(i_len), .i_sha(i_sha),
    .o_valid(ov[1]), .o_ready(rdy[1]), .o_data(od[1]), .o_last(ol[1]),
    .o_id(oid[1]), .o_len(olen[1]), .overflow(oovf[1])
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each frame is a list of results in arrival order, with
  // byte k taken straight from the digest (or its printed hex string)
  typedef struct packed {
    logic [31:0]  id;
    logic [60:0]  len;
    logic [511:0] sha;
  } frame_t;

  frame_t       mq [2][2];
  int           mcnt [2];
  int           midx [2];
  bit           movf [2];
  logic [31:0]  hid [2];
  logic [60:0]  hlen [2];
  logic [103:0] exp_v;
  logic [103:0] obs_v;

  function automatic int frame_len(input int d);
    return (d == 1) ? 129 : 64;
  endfunction

  function automatic logic [7:0] refByte(input logic [511:0] sha, input int k, input bit hex_mode, input bit lf_mode);
    string s;
    int n;
    n = (hex_mode ? 128 : 64) + (lf_mode ? 1 : 0);
    if (lf_mode && k == n - 1) return 8'h0a;
    if (hex_mode) begin
      s = $sformatf("%h", sha);
      return s[k];
    end
    return sha[511 - 8 * k -: 8];
  endfunction

  task automatic modelCycle();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mcnt[d] = 0;
        midx[d] = 0;
        movf[d] = 1'b0;
        hid[d]  = '0;
        hlen[d] = '0;
      end
      obs_v = {ov[d], od[d], ol[d], oid[d], olen[d], oovf[d]};
      if (mcnt[d] > 0) begin
        exp_v = {1'b1, refByte(mq[d][0].sha, midx[d], d == 1, d == 1),
                 (midx[d] == frame_len(d) - 1), mq[d][0].id, mq[d][0].len, movf[d]};
      end else begin
        exp_v = {1'b0, 8'h00, 1'b0, hid[d], hlen[d], movf[d]};
      end
      checkOutput(d == 0 ? "bin_cycle" : "hex_cycle", 128'(obs_v), 128'(exp_v));
      if (!rst) begin
        if (mcnt[d] > 0) begin
          hid[d]  = mq[d][0].id;
          hlen[d] = mq[d][0].len;
          if (rdy[d]) begin
            midx[d]++;
            if (midx[d] == frame_len(d)) begin
              midx[d]  = 0;
              mq[d][0] = mq[d][1];
              mcnt[d]--;
            end
          end
        end
        if (i_valid) begin
          if (mcnt[d] < 2) begin
            mq[d][mcnt[d]] = {i_id, i_len, i_sha};
            mcnt[d]++;
          end else begin
            movf[d] = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      modelCycle();
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  // All stimulus tasks start and end 1ns after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] id, input logic [60:0] len, input logic [511:0] sha);
    i_valid = 1'b1;
    i_id    = id;
    i_len   = len;
    i_sha   = sha;
    idle(1);
    i_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic waitDrain(input int budget, input bit random_ready);
    for (int n = 0; n < budget; n++) begin
      if (ov == 2'b00) break;
      rdy = random_ready ? 2'($urandom) : 2'b11;
      idle(1);
    end
    checkOutput("drain", 128'(ov), 128'(0));
  endtask

  task automatic waitLast(input int d, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (ov[d] && ol[d]) break;
      idle(1);
    end
    checkOutput(d == 0 ? "bin_reach_last" : "hex_reach_last", 128'(ol[d]), 128'(1));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    checkOutput("reset_valid", 128'(ov), 128'(0));
    checkOutput("reset_id", 128'(oid[0]), 128'(0));

    // Abc digest, always ready
    rdy = 2'b11;
    applyStimulus(32'd7, 61'd3, ABC);
    checkOutput("s1_first_valid", 128'(ov), 128'(2'b11));
    checkOutput("s1_first_byte_bin", 128'(od[0]), 128'(8'hdd));
    checkOutput("s1_first_char_hex", 128'(od[1]), 128'(8'h64));
    checkOutput("s1_id_len", 128'({oid[0], olen[0]}), 128'({32'd7, 61'd3}));
    waitLast(0, 200);
    checkOutput("s1_last_byte_bin", 128'(od[0]), 128'(8'h9f));
    waitLast(1, 200);
    checkOutput("s1_last_byte_hex", 128'(od[1]), 128'(8'h0a));
    waitDrain(300, 1'b0);

    // Abc digest under random backpressure
    rdy = 2'($urandom);
    applyStimulus(32'd9, 61'd3, ABC);
    waitDrain(3000, 1'b1);

    // Burst of three with downstream stalled: third result is dropped
    rdy = 2'b00;
    applyStimulus(32'd1, 61'd100, rand512());
    idle(1);
    applyStimulus(32'd2, 61'd200, rand512());
    idle(1);
    applyStimulus(32'd3, 61'd300, rand512());
    idle(1);
    checkOutput("s4_overflow", 128'(oovf), 128'(2'b11));
    checkOutput("s4_head_id", 128'({oid[1], oid[0]}), 128'({32'd1, 32'd1}));
    waitDrain(2000, 1'b0);
    checkOutput("s4_overflow_sticky", 128'(oovf), 128'(2'b11));

    // Reset in the middle of a frame, then restart from byte 0
    rdy = 2'b11;
    applyStimulus(32'd31, 61'd64, rand512());
    idle(20);
    checkOutput("s6_mid_frame_valid", 128'(ov), 128'(2'b11));
    rst = 1'b1;
    idle(1);
    checkOutput("s6_reset_valid", 128'(ov), 128'(0));
    checkOutput("s6_reset_overflow", 128'(oovf), 128'(0));
    rst = 1'b0;
    idle(1);
    applyStimulus(32'd32, 61'd3, ABC);
    checkOutput("s6_restart_bin", 128'({od[0], oid[0]}), 128'({8'hdd, 32'd32}));
    checkOutput("s6_restart_hex", 128'(od[1]), 128'(8'h64));
    waitDrain(400, 1'b0);

    // Full buffer, capture coincides with the last byte of the binary frame
    doReset();
    rdy = 2'b00;
    applyStimulus(32'd11, 61'd1, rand512());
    applyStimulus(32'd12, 61'd2, rand512());
    rdy = 2'b01;
    waitLast(0, 300);
    applyStimulus(32'd13, 61'd3, rand512());
    checkOutput("s5_bin_overflow", 128'(oovf[0]), 128'(0));
    checkOutput("s5_bin_next", 128'({ov[0], oid[0]}), 128'({1'b1, 32'd12}));
    waitDrain(2000, 1'b0);

    // Same again, lined up with the hex frame's final byte
    doReset();
    rdy = 2'b00;
    applyStimulus(32'd21, 61'd1, rand512());
    applyStimulus(32'd22, 61'd2, rand512());
    rdy = 2'b10;
    waitLast(1, 400);
    applyStimulus(32'd23, 61'd3, rand512());
    checkOutput("s5_hex_overflow", 128'(oovf[1]), 128'(0));
    checkOutput("s5_hex_next", 128'({ov[1], oid[1]}), 128'({1'b1, 32'd22}));
    waitDrain(2000, 1'b0);

    // Random traffic and random backpressure
    doReset();
    for (int i = 0; i < 800; i++) begin
      rdy = 2'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        applyStimulus($urandom, 61'({$urandom, $urandom}), rand512());
      end else begin
        idle(1);
      end
    end
    waitDrain(3000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
